// File: rtl/uart_tx_scheduler_pkg.sv
// Shared configuration for the UART TX scheduler: FSM state encodings and parameter defaults.
// The default byte width matches the UART byte width of 8.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_START = 3'd2,
        SEND       = 3'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 31;
    localparam int DEF_WIDTH   = 8;

endpackage

// File: rtl/uart_tx_scheduler_tx_rr_picker.sv
// Combinational round-robin picker: rotate the request vector by the pointer,
// priority-encode from the bottom, then rotate the found offset back to an index.
module tx_rr_picker
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;

    always_comb begin
        int offset;
        int index;
        offset    = 0;
        index     = 0;
        doubled   = {valid, valid};
        rotated   = NUM_REQ'(doubled >> ptr);
        any_valid = |valid;
        // Scan downwards so the lowest set offset (closest to ptr) wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        index = int'(ptr) + offset;
        if (index >= NUM_REQ) begin
            index = index - NUM_REQ;
        end
        winner = ID_W'(index);
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX frame engine between NUM_REQ byte producers.
// Optional Busy-start watchdog enabled by defining TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_ACK,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_DATA_VALID,
    input  logic                     TX_BUSY,
    output logic [ID_W-1:0]          GNT_ID,
    output logic                     FRAME_DONE,
    output logic                     SCHED_ERR
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    if ((1 << ID_W) < NUM_REQ || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_scheduler: illegal NUM_REQ/ID_W/TIMEOUT combination");
    end

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    state_t              state, state_n;
    logic [ID_W-1:0]     ptr, ptr_n;
    logic [NUM_REQ-1:0]  ack_n;
    logic [WIDTH-1:0]    data_n;
    logic                dv_n;
    logic [ID_W-1:0]     gnt_n;
    logic                done_n;
    logic [ID_W-1:0]     winner;
    logic                any_valid;

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err, err_n;
`endif

    tx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid     (REQ_VALID),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        ack_n   = '0;
        data_n  = TX_P_DATA;
        dv_n    = 1'b0;
        gnt_n   = GNT_ID;
        done_n  = 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = err;
`endif
        case (state)
            IDLE: begin
                if (any_valid && !TX_BUSY) begin
                    state_n = GRANT;
                    ack_n   = NUM_REQ'(1) << winner;
                    dv_n    = 1'b1;
                    data_n  = REQ_DATA[int'(winner)*WIDTH +: WIDTH];
                    gnt_n   = winner;
                end
            end
            GRANT: begin
                state_n = WAIT_START;
`ifdef TX_SCHED_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            WAIT_START: begin
                if (TX_BUSY) begin
                    state_n = SEND;
`ifdef TX_SCHED_TIMEOUT_EN
                end else if (cnt == CNT_LAST) begin
                    // Engine never started: drop the byte and move past this requester.
                    state_n = IDLE;
                    err_n   = 1'b1;
                    ptr_n   = next_id(GNT_ID);
                end else begin
                    cnt_n   = cnt + 1'b1;
`endif
                end
            end
            SEND: begin
                // Busy was already seen high on entry, so low here is the falling edge.
                if (!TX_BUSY) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ptr_n   = next_id(GNT_ID);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            ptr           <= '0;
            REQ_ACK       <= '0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            GNT_ID        <= '0;
            FRAME_DONE    <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            REQ_ACK       <= ack_n;
            TX_P_DATA     <= data_n;
            TX_DATA_VALID <= dv_n;
            GNT_ID        <= gnt_n;
            FRAME_DONE    <= done_n;
        end
    end

`ifdef TX_SCHED_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_n;
            err <= err_n;
        end
    end

    assign SCHED_ERR = err;
`else
    assign SCHED_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a producer model, a TX engine model and
// a monitor that checks each issued frame against hand-computed expected grants.
module tb_uart_tx_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  REQ_VALID = '0;
    logic [31:0] REQ_DATA = '0;
    logic [3:0]  REQ_ACK;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        TX_BUSY;
    logic [1:0]  GNT_ID;
    logic        FRAME_DONE;
    logic        SCHED_ERR;

    logic eng_busy = 1'b0;
    logic force_busy = 1'b0;
    logic eng_dead = 1'b0;
    int   busy_len = 10;

    assign TX_BUSY = eng_busy | force_busy;

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(
        .NUM_REQ (4),
        .WIDTH   (8),
        .ID_W    (2),
        .TIMEOUT (31)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_DATA      (REQ_DATA),
        .REQ_ACK       (REQ_ACK),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (TX_BUSY),
        .GNT_ID        (GNT_ID),
        .FRAME_DONE    (FRAME_DONE),
        .SCHED_ERR     (SCHED_ERR)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } grant_t;

    grant_t     exp_q[$];
    logic [7:0] src_q[4][$];
    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int done_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [1:0] id, input logic [7:0] data);
        grant_t g;
        g.id   = id;
        g.data = data;
        exp_q.push_back(g);
        src_q[id].push_back(data);
        done_exp++;
    endtask

    task automatic flush_sources();
        for (int i = 0; i < 4; i++) src_q[i].delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (done_seen != done_exp && n < 600) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        chk({name, "_drain_in_time"}, 32'(n < 600), 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!TX_BUSY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_busy_seen"}, 32'(TX_BUSY), 1);
    endtask

    // Producer: holds each queued byte valid until its ACK is observed.
    initial begin
        logic [3:0] ack_snap;
        forever begin
            @(negedge CLK);
            ack_snap = REQ_ACK;
            @(posedge CLK);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ack_snap[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                REQ_VALID[i] = (src_q[i].size() > 0);
                REQ_DATA[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
            end
        end
    end

    // TX engine model: Busy rises the cycle after Data_Valid and lasts busy_len cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (TX_DATA_VALID && RST && !eng_dead) begin
                @(posedge CLK);
                #1 eng_busy = 1'b1;
                for (int k = 0; k < busy_len; k++) begin
                    @(posedge CLK);
                    if (!RST) break;
                end
                #1 eng_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every Data_Valid and checks FRAME_DONE timing.
    initial begin
        grant_t e;
        logic b1;
        logic b2;
        b1 = 1'b0;
        b2 = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (TX_DATA_VALID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got id=%0d data=0x%0h expected no grant", GNT_ID, TX_P_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt_id", GNT_ID, e.id);
                        chk("tx_p_data", TX_P_DATA, e.data);
                        chk("req_ack", REQ_ACK, 4'b0001 << e.id);
                    end
                end else if (REQ_ACK != 4'b0000) begin
                    chk("ack_without_dv", REQ_ACK, 0);
                end
                if (FRAME_DONE) begin
                    done_seen++;
                    chk("done_after_busy_fall", {b2, b1}, 2'b10);
                end
            end
            b2 = b1;
            b1 = TX_BUSY;
        end
    end

    initial begin
        int  n;
        logic dv_seen;

        repeat (3) @(negedge CLK);
        chk("rst_req_ack", REQ_ACK, 0);
        chk("rst_tx_p_data", TX_P_DATA, 0);
        chk("rst_dv", TX_DATA_VALID, 0);
        chk("rst_gnt_id", GNT_ID, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_sched_err", SCHED_ERR, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Single request from requester 2, then check one-cycle grant latency.
        expect_grant(2'd2, 8'hA5);
        @(negedge CLK);
        chk("t1_dv_not_early", TX_DATA_VALID, 0);
        @(negedge CLK);
        chk("t1_dv_latency", TX_DATA_VALID, 1);
        wait_drain("t1");

        // Pointer now 3; requesters 0 and 1 pending: wrap to 0, then 1.
        expect_grant(2'd0, 8'h31);
        expect_grant(2'd1, 8'h32);
        wait_drain("t2");

        @(negedge CLK);
        RST = 1'b0;
        flush_sources();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // All four pending from pointer 0: order 0,1,2,3,0.
        expect_grant(2'd0, 8'h10);
        expect_grant(2'd1, 8'h11);
        expect_grant(2'd2, 8'h12);
        expect_grant(2'd3, 8'h13);
        expect_grant(2'd0, 8'h14);
        wait_drain("t3");

        // Requester 1 raised during SEND is held off, then granted right after FRAME_DONE.
        expect_grant(2'd3, 8'h55);
        wait_busy("t4");
        expect_grant(2'd1, 8'h66);
        n = 0;
        while (!FRAME_DONE && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("t4_frame_done_seen", FRAME_DONE, 1);
        @(negedge CLK);
        chk("t4_grant_first_idle", TX_DATA_VALID, 1);
        wait_drain("t4");

        // Busy already high in IDLE: no grant until it drops.
        force_busy = 1'b1;
        src_q[2].push_back(8'h77);
        dv_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (TX_DATA_VALID) dv_seen = 1'b1;
        end
        chk("t5_no_grant_while_busy", dv_seen, 0);
        void'(src_q[2].pop_front());
        expect_grant(2'd2, 8'h77);
        force_busy = 1'b0;
        wait_drain("t5");

        // Reset during SEND clears everything at once.
        expect_grant(2'd1, 8'h88);
        done_exp--;
        wait_busy("t6");
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t6_rst_req_ack", REQ_ACK, 0);
        chk("t6_rst_tx_p_data", TX_P_DATA, 0);
        chk("t6_rst_dv", TX_DATA_VALID, 0);
        chk("t6_rst_gnt_id", GNT_ID, 0);
        chk("t6_rst_frame_done", FRAME_DONE, 0);
        flush_sources();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        expect_grant(2'd0, 8'h99);
        expect_grant(2'd2, 8'h9A);
        wait_drain("t6");

`ifdef TX_SCHED_TIMEOUT_EN
        // Engine never raises Busy: watchdog fires 32 cycles after the grant.
        eng_dead = 1'b1;
        expect_grant(2'd3, 8'hEE);
        done_exp--;
        n = 0;
        while (!TX_DATA_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("t7_grant_seen", TX_DATA_VALID, 1);
        n = 0;
        while (!SCHED_ERR && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("t7_timeout_cycle", n, 32);
        repeat (5) @(negedge CLK);
        chk("t7_err_sticky", SCHED_ERR, 1);
        eng_dead = 1'b0;
`else
        chk("sched_err_tied_low", SCHED_ERR, 0);
`endif

        chk("frames_done_total", done_seen, done_exp);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400000");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART TX frame engine between NUM_REQ byte producers.
- Accepts bytes through a valid/ack handshake and issues them to the TX engine one frame at a time as a single-cycle Data_Valid pulse.
- Waits out the engine's Busy window, then grants the next requester.
- Sits between the system-side producers (register file, command echo, status reporter) and the UART TX top.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- WIDTH, 8, data byte width; matches the UART `WIDTH` macro.
- ID_W, 2, width of the grant index; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 31, cycles allowed for Busy to rise after a Data_Valid pulse (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester byte pending.
- REQ_DATA  in  NUM_REQ*WIDTH  packed bytes; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_ACK  out  NUM_REQ  one-hot, one-cycle pulse; the byte has been consumed.
- TX_P_DATA  out  WIDTH  registered byte presented to the TX engine.
- TX_DATA_VALID  out  1  one-cycle pulse starting a frame.
- TX_BUSY  in  1  TX engine busy (frame in progress).
- GNT_ID  out  ID_W  index of the current or last granted requester.
- FRAME_DONE  out  1  one-cycle pulse when the granted frame finishes.
- SCHED_ERR  out  1  sticky timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: state IDLE; REQ_ACK=0; TX_P_DATA=0; TX_DATA_VALID=0; GNT_ID=0; FRAME_DONE=0; SCHED_ERR=0; round-robin pointer PTR=0. All outputs are registered.
- Handshake: a requester holds REQ_VALID and its byte stable until it sees REQ_ACK. It may withdraw REQ_VALID before ACK. Arbitration uses the REQ_VALID value in the decision cycle only.
- IDLE -> GRANT: when any REQ_VALID=1 and TX_BUSY=0. Otherwise stay in IDLE.
- GRANT (1 cycle), on the transition edge:
  - Winner = first set REQ_VALID bit searching PTR, PTR+1, ..., wrapping modulo NUM_REQ.
  - Register TX_P_DATA <= winner byte and GNT_ID <= winner.
  - Pulse REQ_ACK[winner] and TX_DATA_VALID together, both visible in the GRANT cycle.
  - Then go to WAIT_START.
- WAIT_START: when TX_BUSY=1, go to SEND.
- SEND: on the TX_BUSY falling edge (seen 1 then 0):
  - Pulse FRAME_DONE.
  - PTR <= GNT_ID+1, wrapping NUM_REQ-1 -> 0.
  - Go to IDLE.
- Latency:
  - REQ_VALID rising in IDLE -> TX_DATA_VALID: 1 cycle.
  - TX_BUSY falling -> FRAME_DONE: 1 cycle.
  - Back-to-back frames need a minimum of one IDLE cycle between FRAME_DONE and the next TX_DATA_VALID.
- REQ_VALID bits asserted during WAIT_START or SEND are held off, with no ACK, until IDLE.
- TX_BUSY already high in IDLE (engine shared or still finishing): no grant is issued.
- Single requester continuously valid: it is granted every frame, because the pointer search wraps back to it.
- Reset mid-frame: all state clears immediately. The in-flight requester is not re-acked, since its ACK was already given. TX_P_DATA clears to 0.
- Illegal state encoding: next state is IDLE.
- Unused REQ_VALID bits above NUM_REQ do not exist; GNT_ID never exceeds NUM_REQ-1.

Optional Feature:
- Macro TX_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_START runs a counter of width $clog2(TIMEOUT+1), cleared on GRANT.
  - If TX_BUSY has not risen after TIMEOUT cycles: set SCHED_ERR (sticky until reset), go to IDLE, and advance PTR past the granted requester.
  - No FRAME_DONE is issued and the byte is dropped.
- Undefined: no counter; WAIT_START waits indefinitely; SCHED_ERR is tied 0.

Decomposition:
- Shared config header (alongside the existing UART macros) holds:
  - state encodings: IDLE=3'd0, GRANT=3'd1, WAIT_START=3'd2, SEND=3'd3;
  - the defaults for NUM_REQ and TIMEOUT;
  - reuse of `WIDTH.
- One sub-module, tx_rr_picker: combinational rotate / priority-encode / rotate-back.
  - Inputs: REQ_VALID and PTR.
  - Outputs: winner index and any_valid.
- The FSM, registers and timeout counter stay in uart_tx_scheduler.

Test Plan:
- Single request: REQ_VALID=4'b0100, byte 0xA5, TX_BUSY idle -> next cycle TX_DATA_VALID=1, REQ_ACK=4'b0100, TX_P_DATA=0xA5, GNT_ID=2. Model Busy high 10 cycles -> FRAME_DONE one cycle after Busy falls; PTR=3.
- Round-robin fairness: all four REQ_VALID held high, bytes 0x10..0x13 -> grant order 0,1,2,3,0. Each ACK fires exactly once per frame.
- Wrap and skip: PTR=3 with REQ_VALID=4'b0011 -> requester 0 granted, then requester 1.
- Request during frame: REQ_VALID[1] raised while in SEND -> no ACK until FRAME_DONE. Granted on the first IDLE cycle afterwards.
- Reset mid-frame: assert RST low during SEND -> all outputs 0 asynchronously, GNT_ID=0. After release, the requester 0 request is granted first.
- TX_SCHED_TIMEOUT_EN with TIMEOUT=31: TX_BUSY stuck at 0 after a grant -> SCHED_ERR=1 at cycle 32 after the grant. FSM returns to IDLE with no FRAME_DONE. SCHED_ERR stays 1 until reset.
